// File: rtl/jk_pkg.sv
// Shared encodings for the JK mode counter: operating modes and per-cell JK codes.
package jk_pkg;
  localparam logic [1:0] MODE_RAW  = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit with synchronous reset to a per-bit value and a load override.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ce,
  input  logic ld,
  input  logic ld_val,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next-state: load wins over the JK code; ce gates everything except reset.
  always_comb begin
    q_d = q_q;
    if (ce) begin
      if (ld) begin
        q_d = ld_val;
      end else begin
        case ({j, k})
          JK_HOLD: q_d = q_q;
          JK_CLR:  q_d = 1'b0;
          JK_SET:  q_d = 1'b1;
          JK_TGL:  q_d = ~q_q;
          default: q_d = q_q;
        endcase
      end
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mode_counter.sv
// WIDTH-bit register of JK cells running as raw JK, up-counter, down-counter or hold,
// with parallel load, optional saturation, a terminal-count flag and a wrap/clamp event pulse.
module jk_mode_counter
  import jk_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] up_tgl_s;
  logic [WIDTH-1:0] dn_tgl_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic             all_ones_s;
  logic             all_zero_s;
  logic             at_end_s;
  logic             evt_q;
  logic             evt_d;

  assign all_ones_s = &q_s;
  assign all_zero_s = ~|q_s;

  // Toggle chains: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_tgl_s    = '0;
    dn_tgl_s    = '0;
    up_tgl_s[0] = 1'b1;
    dn_tgl_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_tgl_s[i] = up_tgl_s[i-1] & q_s[i-1];
      dn_tgl_s[i] = dn_tgl_s[i-1] & ~q_s[i-1];
    end
  end

  // Per-bit J/K selection; a saturated end value zeroes the chain so the cells hold.
  always_comb begin
    j_s      = '0;
    k_s      = '0;
    at_end_s = 1'b0;
    case (mode)
      MODE_RAW: begin
        j_s = j;
        k_s = k;
      end
      MODE_UP: begin
        at_end_s = all_ones_s;
        if ((SATURATE != 0) && all_ones_s) begin
          j_s = '0;
          k_s = '0;
        end else begin
          j_s = up_tgl_s;
          k_s = up_tgl_s;
        end
      end
      MODE_DOWN: begin
        at_end_s = all_zero_s;
        if ((SATURATE != 0) && all_zero_s) begin
          j_s = '0;
          k_s = '0;
        end else begin
          j_s = dn_tgl_s;
          k_s = dn_tgl_s;
        end
      end
      MODE_HOLD: begin
        j_s = '0;
        k_s = '0;
      end
      default: begin
        j_s = '0;
        k_s = '0;
      end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[g]),
      .ce      (en),
      .ld      (load),
      .ld_val  (load_val[g]),
      .j       (j_s[g]),
      .k       (k_s[g]),
      .q       (q_s[g])
    );
  end

  // Event fires on any counting edge that starts at the end value (wrap or clamp).
  always_comb begin
    evt_d = 1'b0;
    if (en && !load) begin
      evt_d = at_end_s;
    end else begin
      evt_d = 1'b0;
    end
  end

  // Event pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign q   = q_s;
  assign evt = evt_q;
  assign tc  = ((mode == MODE_UP) && all_ones_s) || ((mode == MODE_DOWN) && all_zero_s);

endmodule

// File: tb/tb_jk_mode_counter.sv
// Scoreboard bench: a wrapping and a saturating WIDTH=4 counter share stimulus; an
// arithmetic reference model queues expectations that a monitor checks after each edge.
module tb_jk_mode_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q0, q1;
  logic       tc0, tc1, evt0, evt1;

  localparam logic [3:0] RV1 = 4'hA;

  typedef struct {
    logic [3:0] q0;
    logic       e0;
    logic       t0;
    logic [3:0] q1;
    logic       e1;
    logic       t1;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [3:0] m0, m1;

  jk_mode_counter #(.WIDTH(4), .SATURATE(0), .RST_VAL(4'h0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .mode(mode),
    .j(j), .k(k), .q(q0), .tc(tc0), .evt(evt0)
  );

  jk_mode_counter #(.WIDTH(4), .SATURATE(1), .RST_VAL(RV1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .mode(mode),
    .j(j), .k(k), .q(q1), .tc(tc1), .evt(evt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: returns {evt, q} after one edge from the behavioural rules.
  function automatic logic [4:0] model(input logic [3:0] cur, input bit sat, input logic [3:0] rv,
                                       input logic r, input logic e, input logic l,
                                       input logic [3:0] lv, input logic [1:0] m,
                                       input logic [3:0] jj, input logic [3:0] kk);
    if (r) return {1'b0, rv};
    if (!e) return {1'b0, cur};
    if (l) return {1'b0, lv};
    case (m)
      2'd0: return {1'b0, (~cur & jj) | (cur & ~kk)};
      2'd1: if (cur == 4'd15) return {1'b1, sat ? cur : 4'd0};
            else return {1'b0, cur + 4'd1};
      2'd2: if (cur == 4'd0) return {1'b1, sat ? cur : 4'd15};
            else return {1'b0, cur - 4'd1};
      default: return {1'b0, cur};
    endcase
  endfunction

  function automatic logic tc_of(input logic [3:0] v, input logic [1:0] m);
    return (m == 2'd1 && v == 4'd15) || (m == 2'd2 && v == 4'd0);
  endfunction

  task automatic step(input logic r, input logic e, input logic l, input logic [3:0] lv,
                      input logic [1:0] m, input logic [3:0] jj, input logic [3:0] kk,
                      input string tag);
    logic [4:0] n0, n1;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; load = l; load_val = lv; mode = m; j = jj; k = kk;
    n0 = model(m0, 1'b0, 4'h0, r, e, l, lv, m, jj, kk);
    n1 = model(m1, 1'b1, RV1, r, e, l, lv, m, jj, kk);
    m0 = n0[3:0];
    m1 = n1[3:0];
    x.q0 = n0[3:0]; x.e0 = n0[4]; x.t0 = tc_of(n0[3:0], m);
    x.q1 = n1[3:0]; x.e1 = n1[4]; x.t1 = tc_of(n1[3:0], m);
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every edge presents a new state; pop and compare one expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk({x.tag, "/q0"},   q0, x.q0);
        chk({x.tag, "/evt0"}, {3'b0, evt0}, {3'b0, x.e0});
        chk({x.tag, "/tc0"},  {3'b0, tc0},  {3'b0, x.t0});
        chk({x.tag, "/q1"},   q1, x.q1);
        chk({x.tag, "/evt1"}, {3'b0, evt1}, {3'b0, x.e1});
        chk({x.tag, "/tc1"},  {3'b0, tc1},  {3'b0, x.t1});
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; en = 1'b1; load = 1'b0; load_val = 4'h0; mode = 2'd1; j = 4'h0; k = 4'h0;
    m0 = 4'h0; m1 = RV1;
    step(1'b1, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, "reset_a");
    step(1'b1, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, "reset_b");
    step(1'b0, 1'b1, 1'b1, 4'hA, 2'd0, 4'h0, 4'h0, "raw_ld");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 4'h5, 4'h9, "raw_jk");
    step(1'b0, 1'b1, 1'b1, 4'hE, 2'd1, 4'h0, 4'h0, "up_ld");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, "up_f");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, "up_wrap");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, "up_pin");
    step(1'b0, 1'b1, 1'b1, 4'h1, 2'd2, 4'h0, 4'h0, "dn_ld");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd2, 4'h0, 4'h0, "dn_0");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd2, 4'h0, 4'h0, "dn_sat1");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd2, 4'h0, 4'h0, "dn_sat2");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd1, 4'h0, 4'h0, "up_run");
    step(1'b0, 1'b1, 1'b1, 4'h7, 2'd1, 4'h0, 4'h0, "up_load7");
    step(1'b0, 1'b0, 1'b1, 4'h3, 2'd1, 4'hF, 4'hF, "en_off");
    step(1'b0, 1'b1, 1'b0, 4'h0, 2'd3, 4'hF, 4'hF, "hold");
    step(1'b0, 1'b1, 1'b1, 4'h9, 2'd1, 4'h0, 4'h0, "up_ld9");
    step(1'b1, 1'b1, 1'b1, 4'h6, 2'd1, 4'h0, 4'h0, "rst_over_ld");
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) == 0), 4'($urandom), 2'($urandom),
           4'($urandom), 4'($urandom), "rand");
    end
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
